// File: rtl/pipe_stage_skid_reg.sv
// Pipeline boundary register with a valid/ready handshake, a 2-entry skid
// buffer and a synchronous flush. Ports: clk, rst_n, in_valid/in_ready/
// in_data/in_ctrl (upstream), flush, out_valid/out_ready/out_data/out_ctrl
// (downstream), stall_cnt (only when PIPE_STALL_CNT_EN is defined).
module pipe_stage_skid_reg #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl
`ifdef PIPE_STALL_CNT_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt
`endif
);

  if (DATA_W < 1 || CTRL_W < 1 || CNT_W < 1) begin : g_bad_param
    $error("pipe_stage_skid_reg: widths must be >= 1");
  end

  logic              main_valid;
  logic              skid_valid;
  logic [DATA_W-1:0] skid_data;
  logic [CTRL_W-1:0] skid_ctrl;
  logic              acc_in;
  logic              main_free;

  // in_ready comes straight from a flop: no path from out_ready.
  assign in_ready  = !skid_valid;
  assign out_valid = main_valid;
  assign acc_in    = in_valid & !skid_valid;
  // Main slot can take a new entry this edge (empty or draining).
  assign main_free = !main_valid | out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      out_data   <= '0;
      out_ctrl   <= '0;
      skid_data  <= '0;
      skid_ctrl  <= '0;
    end else if (flush) begin
      // Kill both entries; data is left alone, ctrl is zeroed.
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      out_ctrl   <= '0;
      skid_ctrl  <= '0;
    end else if (main_free) begin
      if (skid_valid) begin
        // Skid drains first to keep FIFO order.
        main_valid <= 1'b1;
        out_data   <= skid_data;
        out_ctrl   <= skid_ctrl;
        skid_valid <= 1'b0;
      end else if (acc_in) begin
        main_valid <= 1'b1;
        out_data   <= in_data;
        out_ctrl   <= in_ctrl;
      end else begin
        main_valid <= 1'b0;
        out_ctrl   <= '0;
      end
    end else if (acc_in) begin
      skid_valid <= 1'b1;
      skid_data  <= in_data;
      skid_ctrl  <= in_ctrl;
    end
  end

`ifdef PIPE_STALL_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (main_valid && !out_ready && !flush
                 && stall_cnt != {CNT_W{1'b1}}) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end
`endif

endmodule
